// File: rtl/stage_mem_lsu_pkg.sv
// Shared opcodes, FSM/size encodings and opcode decode for the stage_mem_lsu slice.
package stage_mem_lsu_pkg;

    localparam logic RESET_ENABLE = 1'b0;

    localparam logic [7:0] OP_LB  = 8'h01;
    localparam logic [7:0] OP_LBU = 8'h02;
    localparam logic [7:0] OP_LH  = 8'h03;
    localparam logic [7:0] OP_LHU = 8'h04;
    localparam logic [7:0] OP_LW  = 8'h05;
    localparam logic [7:0] OP_SB  = 8'h06;
    localparam logic [7:0] OP_SH  = 8'h07;
    localparam logic [7:0] OP_SW  = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef struct packed {
        logic  is_mem;
        logic  is_store;
        logic  sign_ext;
        size_e size;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [7:0] op);
        mem_op_t d;
        d = '{is_mem: 1'b1, is_store: 1'b0, sign_ext: 1'b0, size: SIZE_W};
        case (op)
            OP_LB:   begin d.sign_ext = 1'b1; d.size = SIZE_B; end
            OP_LBU:  d.size = SIZE_B;
            OP_LH:   begin d.sign_ext = 1'b1; d.size = SIZE_H; end
            OP_LHU:  d.size = SIZE_H;
            OP_LW:   d.size = SIZE_W;
            OP_SB:   begin d.is_store = 1'b1; d.size = SIZE_B; end
            OP_SH:   begin d.is_store = 1'b1; d.size = SIZE_H; end
            OP_SW:   begin d.is_store = 1'b1; d.size = SIZE_W; end
            default: d.is_mem = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stage_mem_lsu_mem_lane_align.sv
// Big-endian byte-lane steering: store select/replication and load extract/extend.
module mem_lane_align
    import stage_mem_lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned LANES = DATA_WIDTH / 8,
    localparam int unsigned OFF_W = $clog2(LANES)
) (
    input  size_e                  st_size,
    input  logic [OFF_W-1:0]       st_offset,
    input  logic [31:0]            st_data,
    output logic [LANES-1:0]       st_select,
    output logic [DATA_WIDTH-1:0]  st_wdata,
    input  size_e                  ld_size,
    input  logic                   ld_sign,
    input  logic [OFF_W-1:0]       ld_offset,
    input  logic [DATA_WIDTH-1:0]  ld_rdata,
    output logic [31:0]            ld_result
);

    logic [OFF_W-1:0]      st_off_al;
    logic [OFF_W-1:0]      ld_off_al;
    logic [DATA_WIDTH-1:0] ld_shifted;

    // Lane k maps to select bit LANES-1-k; offsets aligned down to access size.
    always_comb begin
        st_select = '0;
        st_wdata  = '0;
        st_off_al = st_offset;
        case (st_size)
            SIZE_B: begin
                st_select = LANES'(1) << (OFF_W'(LANES - 1) - st_off_al);
                st_wdata  = {(LANES){st_data[7:0]}};
            end
            SIZE_H: begin
                st_off_al = st_offset & ~OFF_W'(1);
                st_select = LANES'(2'b11) << (OFF_W'(LANES - 2) - st_off_al);
                st_wdata  = {(LANES / 2){st_data[15:0]}};
            end
            default: begin
                st_off_al = st_offset & ~OFF_W'(3);
                st_select = LANES'(4'hF) << (OFF_W'(LANES - 4) - st_off_al);
                st_wdata  = {(LANES / 4){st_data}};
            end
        endcase
    end

    // Shift the addressed bytes to the top of the bus, then take/extend them.
    always_comb begin
        ld_result = '0;
        case (ld_size)
            SIZE_B:  ld_off_al = ld_offset;
            SIZE_H:  ld_off_al = ld_offset & ~OFF_W'(1);
            default: ld_off_al = ld_offset & ~OFF_W'(3);
        endcase
        ld_shifted = ld_rdata << {ld_off_al, 3'b000};
        case (ld_size)
            SIZE_B:  ld_result = {{24{ld_sign & ld_shifted[DATA_WIDTH-1]}}, ld_shifted[DATA_WIDTH-1 -: 8]};
            SIZE_H:  ld_result = {{16{ld_sign & ld_shifted[DATA_WIDTH-1]}}, ld_shifted[DATA_WIDTH-1 -: 16]};
            default: ld_result = ld_shifted[DATA_WIDTH-1 -: 32];
        endcase
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// Multi-cycle MEM-stage load/store unit on a req/grant/rvalid bus.
// Optional STAGE_MEM_ALIGN_CHECK_EN traps misaligned half/word accesses.
module stage_mem_lsu
    import stage_mem_lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               instruction,
    input  logic [7:0]                operator,
    input  logic [31:0]               operand_a,
    input  logic [31:0]               operand_b,
    input  logic                      reg_write_enable_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg_write_address_i,
    input  logic [31:0]               reg_write_data_i,
    output logic                      mem_req,
    output logic                      mem_write,
    output logic [ADDR_WIDTH-1:0]     mem_address,
    output logic [DATA_WIDTH/8-1:0]   mem_select,
    output logic [DATA_WIDTH-1:0]     mem_write_data,
    input  logic                      mem_grant,
    input  logic                      mem_read_valid,
    input  logic [DATA_WIDTH-1:0]     mem_read_data,
    output logic                      out_valid,
    output logic                      reg_write_enable_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_write_address_o,
    output logic [31:0]               reg_write_data_o,
`ifdef STAGE_MEM_ALIGN_CHECK_EN
    output logic                      exception_misaligned,
    output logic [ADDR_WIDTH-1:0]     exception_address,
`endif
    output logic                      stall_request
);

    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(LANES);

    state_e                    state_q, state_d;
    logic                      in_ready_q, in_ready_d, stall_q, stall_d;
    logic                      mem_req_q, mem_req_d, mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]     mem_address_q, mem_address_d;
    logic [LANES-1:0]          mem_select_q, mem_select_d;
    logic [DATA_WIDTH-1:0]     mem_write_data_q, mem_write_data_d;
    size_e                     ld_size_q, ld_size_d;
    logic                      ld_sign_q, ld_sign_d;
    logic [OFF_W-1:0]          ld_off_q, ld_off_d;
    logic                      rd_we_q, rd_we_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                      out_valid_q, out_valid_d, we_o_q, we_o_d;
    logic [REG_ADDR_WIDTH-1:0] wa_o_q, wa_o_d;
    logic [31:0]               wd_o_q, wd_o_d;
    mem_op_t                   op_c;
    logic [ADDR_WIDTH-1:0]     addr_c;
    logic [LANES-1:0]          st_select_c;
    logic [DATA_WIDTH-1:0]     st_wdata_c;
    logic [31:0]               ld_result_c;
    logic                      unused_ok;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
    logic                      misaligned_c;
    logic                      exc_q, exc_d;
    logic [ADDR_WIDTH-1:0]     exc_addr_q, exc_addr_d;
`endif

    assign unused_ok = ^instruction[31:16];
    assign op_c      = decode_op(operator);
    assign addr_c    = ADDR_WIDTH'(operand_a) + ADDR_WIDTH'($signed(instruction[15:0]));
`ifdef STAGE_MEM_ALIGN_CHECK_EN
    assign misaligned_c = ((op_c.size == SIZE_H) && addr_c[0]) ||
                          ((op_c.size == SIZE_W) && (addr_c[1:0] != 2'b00));
`endif

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .st_size   (op_c.size),
        .st_offset (addr_c[OFF_W-1:0]),
        .st_data   (operand_b),
        .st_select (st_select_c),
        .st_wdata  (st_wdata_c),
        .ld_size   (ld_size_q),
        .ld_sign   (ld_sign_q),
        .ld_offset (ld_off_q),
        .ld_rdata  (mem_read_data),
        .ld_result (ld_result_c)
    );

    always_comb begin
        state_d          = state_q;
        mem_req_d        = mem_req_q;
        mem_write_d      = mem_write_q;
        mem_address_d    = mem_address_q;
        mem_select_d     = mem_select_q;
        mem_write_data_d = mem_write_data_q;
        ld_size_d        = ld_size_q;
        ld_sign_d        = ld_sign_q;
        ld_off_d         = ld_off_q;
        rd_we_d          = rd_we_q;
        rd_addr_d        = rd_addr_q;
        out_valid_d      = 1'b0;
        we_o_d           = we_o_q;
        wa_o_d           = wa_o_q;
        wd_o_d           = wd_o_q;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
        exc_d            = 1'b0;
        exc_addr_d       = exc_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !op_c.is_mem) begin
                    out_valid_d = 1'b1;
                    we_o_d      = reg_write_enable_i;
                    wa_o_d      = reg_write_address_i;
                    wd_o_d      = reg_write_data_i;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
                end else if (in_valid && misaligned_c) begin
                    out_valid_d = 1'b1;
                    we_o_d      = 1'b0;
                    wa_o_d      = reg_write_address_i;
                    wd_o_d      = '0;
                    exc_d       = 1'b1;
                    exc_addr_d  = addr_c;
`endif
                end else if (in_valid) begin
                    state_d          = ST_REQ;
                    mem_req_d        = 1'b1;
                    mem_write_d      = op_c.is_store;
                    mem_address_d    = addr_c & ~ADDR_WIDTH'(LANES - 1);
                    mem_select_d     = st_select_c;
                    mem_write_data_d = op_c.is_store ? st_wdata_c : '0;
                    ld_size_d        = op_c.size;
                    ld_sign_d        = op_c.sign_ext;
                    ld_off_d         = addr_c[OFF_W-1:0];
                    rd_we_d          = reg_write_enable_i;
                    rd_addr_d        = reg_write_address_i;
                end
            end
            ST_REQ: begin
                if (mem_grant) begin
                    mem_req_d = 1'b0;
                    if (mem_write_q) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b1;
                        we_o_d      = 1'b0;
                        wa_o_d      = rd_addr_q;
                        wd_o_d      = '0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_read_valid) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    we_o_d      = rd_we_q;
                    wa_o_d      = rd_addr_q;
                    wd_o_d      = ld_result_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
        stall_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ENABLE) begin
            state_q          <= ST_IDLE;
            in_ready_q       <= 1'b1;
            stall_q          <= 1'b0;
            mem_req_q        <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_select_q     <= '0;
            mem_write_data_q <= '0;
            ld_size_q        <= SIZE_B;
            ld_sign_q        <= 1'b0;
            ld_off_q         <= '0;
            rd_we_q          <= 1'b0;
            rd_addr_q        <= '0;
            out_valid_q      <= 1'b0;
            we_o_q           <= 1'b0;
            wa_o_q           <= '0;
            wd_o_q           <= '0;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
            exc_q            <= 1'b0;
            exc_addr_q       <= '0;
`endif
        end else begin
            state_q          <= state_d;
            in_ready_q       <= in_ready_d;
            stall_q          <= stall_d;
            mem_req_q        <= mem_req_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_select_q     <= mem_select_d;
            mem_write_data_q <= mem_write_data_d;
            ld_size_q        <= ld_size_d;
            ld_sign_q        <= ld_sign_d;
            ld_off_q         <= ld_off_d;
            rd_we_q          <= rd_we_d;
            rd_addr_q        <= rd_addr_d;
            out_valid_q      <= out_valid_d;
            we_o_q           <= we_o_d;
            wa_o_q           <= wa_o_d;
            wd_o_q           <= wd_o_d;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
            exc_q            <= exc_d;
            exc_addr_q       <= exc_addr_d;
`endif
        end
    end

    assign in_ready            = in_ready_q;
    assign stall_request       = stall_q;
    assign mem_req             = mem_req_q;
    assign mem_write           = mem_write_q;
    assign mem_address         = mem_address_q;
    assign mem_select          = mem_select_q;
    assign mem_write_data      = mem_write_data_q;
    assign out_valid           = out_valid_q;
    assign reg_write_enable_o  = we_o_q;
    assign reg_write_address_o = wa_o_q;
    assign reg_write_data_o    = wd_o_q;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
    assign exception_misaligned = exc_q;
    assign exception_address    = exc_addr_q;
`endif

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Randomized self-checking bench for stage_mem_lsu against a byte-level reference model.
module tb_stage_mem_lsu;
    import stage_mem_lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic [7:0]  operator = '0;
    logic [31:0] operand_a = '0, operand_b = '0;
    logic        reg_write_enable_i = 1'b0;
    logic [4:0]  reg_write_address_i = '0;
    logic [31:0] reg_write_data_i = '0;
    logic        mem_req, mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_select;
    logic [31:0] mem_write_data;
    logic        mem_grant = 1'b0, mem_read_valid = 1'b0;
    logic [31:0] mem_read_data = '0;
    logic        out_valid, reg_write_enable_o;
    logic [4:0]  reg_write_address_o;
    logic [31:0] reg_write_data_o;
    logic        stall_request;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
    logic        exception_misaligned;
    logic [31:0] exception_address;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    stage_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .operator(operator),
        .operand_a(operand_a), .operand_b(operand_b),
        .reg_write_enable_i(reg_write_enable_i), .reg_write_address_i(reg_write_address_i),
        .reg_write_data_i(reg_write_data_i),
        .mem_req(mem_req), .mem_write(mem_write), .mem_address(mem_address),
        .mem_select(mem_select), .mem_write_data(mem_write_data),
        .mem_grant(mem_grant), .mem_read_valid(mem_read_valid), .mem_read_data(mem_read_data),
        .out_valid(out_valid), .reg_write_enable_o(reg_write_enable_o),
        .reg_write_address_o(reg_write_address_o), .reg_write_data_o(reg_write_data_o),
`ifdef STAGE_MEM_ALIGN_CHECK_EN
        .exception_misaligned(exception_misaligned), .exception_address(exception_address),
`endif
        .stall_request(stall_request)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    // One complete operation: accept, bus handshake, write-back pulse.
    task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [15:0] off,
                         input logic [31:0] b, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input int gdly, input int rdly,
                         input logic [31:0] rdata);
        logic [31:0] addr, ewd, eld, val;
        logic [3:0]  esel;
        logic        is_mem, is_st, sgn, mis;
        int          n, base;
        addr   = a + {{16{off[15]}}, off};
        is_mem = (op >= 8'h01) && (op <= 8'h08);
        is_st  = (op >= 8'h06) && (op <= 8'h08);
        sgn    = (op == OP_LB) || (op == OP_LH);
        n      = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
                 (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
        base   = int'(addr[1:0]) - (int'(addr[1:0]) % n);
        mis    = (int'(addr[1:0]) % n) != 0;
        esel   = '0;
        for (int i = 0; i < n; i++) esel[3 - (base + i)] = 1'b1;
        ewd = '0;
        for (int l = 0; l < 4; l++) begin
            val = (b >> (8 * (n - 1 - (l % n)))) & 32'hFF;
            ewd = ewd | (val << (24 - 8 * l));
        end
        eld = '0;
        for (int i = 0; i < n; i++) eld = (eld << 8) | ((rdata >> (24 - 8 * (base + i))) & 32'hFF);
        if (sgn && eld[8 * n - 1]) eld = eld | ~((32'h1 << (8 * n)) - 32'h1);

        @(negedge clock);
        check("idle_ready", in_ready, 1);
        check("pulse_drop", out_valid, 0);
`ifdef STAGE_MEM_ALIGN_CHECK_EN
        check("exc_drop", exception_misaligned, 0);
`endif
        in_valid = 1'b1; operator = op; operand_a = a; operand_b = b;
        instruction = {16'($urandom), off};
        reg_write_enable_i = we; reg_write_address_i = wa; reg_write_data_i = wd;
        @(negedge clock);
        in_valid = 1'b0; operator = 8'h00; operand_a = $urandom; reg_write_data_i = $urandom;
        if (!is_mem) begin
            check("pt_valid", out_valid, 1);
            check("pt_we", reg_write_enable_o, we);
            check("pt_wa", reg_write_address_o, wa);
            check("pt_wd", reg_write_data_o, wd);
            check("pt_noreq", mem_req, 0);
`ifdef STAGE_MEM_ALIGN_CHECK_EN
        end else if (mis) begin
            check("mis_noreq", mem_req, 0);
            check("mis_valid", out_valid, 1);
            check("mis_we", reg_write_enable_o, 0);
            check("mis_exc", exception_misaligned, 1);
            check("mis_addr", exception_address, addr);
`endif
        end else begin
            check("req", mem_req, 1);
            check("req_write", mem_write, is_st);
            check("req_addr", mem_address, {addr[31:2], 2'b00});
            check("req_sel", mem_select, esel);
            if (is_st) check("req_wdata", mem_write_data, ewd);
            check("req_stall", {stall_request, in_ready}, 2'b10);
            for (int i = 0; i < gdly; i++) begin
                @(negedge clock);
                check("req_hold", {mem_req, mem_address, mem_select}, {1'b1, addr[31:2], 2'b00, esel});
            end
            mem_grant = 1'b1;
            mem_read_valid = !is_st;
            mem_read_data = ~rdata;
            @(negedge clock);
            mem_grant = 1'b0; mem_read_valid = 1'b0;
            if (is_st) begin
                check("st_valid", out_valid, 1);
                check("st_we", reg_write_enable_o, 0);
                check("st_noreq", mem_req, 0);
            end else begin
                check("ld_reqdrop", mem_req, 0);
                check("ld_early", out_valid, 0);
                for (int i = 0; i < rdly; i++) begin
                    @(negedge clock);
                    check("ld_wait", {out_valid, stall_request, mem_req}, 3'b010);
                end
                mem_read_valid = 1'b1; mem_read_data = rdata;
                @(negedge clock);
                mem_read_valid = 1'b0; mem_read_data = $urandom;
                check("ld_valid", out_valid, 1);
                check("ld_we", reg_write_enable_o, we);
                check("ld_wa", reg_write_address_o, wa);
                check("ld_wd", reg_write_data_o, eld);
            end
        end
    endtask

    initial begin
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_outs", {mem_req, mem_write, mem_address, mem_select, mem_write_data,
                           out_valid, reg_write_enable_o, stall_request}, '0);
        check("rst_wb", {reg_write_address_o, reg_write_data_o}, '0);
        @(negedge clock); reset = 1'b1;

        do_op(OP_SW,  32'h100, 16'h0004, 32'hDEADBEEF, 1'b1, 5'd3, 32'h0, 2, 0, 32'h0);
        do_op(OP_LB,  32'h103, 16'h0000, 32'h0, 1'b1, 5'd7, 32'h0, 0, 1, 32'h000000F0);
        do_op(OP_LBU, 32'h103, 16'h0000, 32'h0, 1'b1, 5'd8, 32'h0, 1, 0, 32'h000000F0);
        do_op(OP_LH,  32'h102, 16'h0000, 32'h0, 1'b1, 5'd9, 32'h0, 0, 2, 32'h12348001);
        do_op(OP_LHU, 32'h102, 16'h0000, 32'h0, 1'b1, 5'd10, 32'h0, 1, 1, 32'h12348001);
        do_op(OP_SB,  32'h0FFFFFFF, 16'h0001, 32'h000000AB, 1'b0, 5'd0, 32'h0, 0, 0, 32'h0);
        do_op(OP_LW,  32'hFFFFFFFF, 16'h0001, 32'h0, 1'b1, 5'd1, 32'h0, 0, 0, 32'hCAFEF00D);
        do_op(OP_LW,  32'h101, 16'h0000, 32'h0, 1'b1, 5'd2, 32'h0, 0, 0, 32'h89ABCDEF);
        do_op(OP_SH,  32'h200, 16'hFFFF, 32'h00001234, 1'b1, 5'd4, 32'h0, 1, 0, 32'h0);
        do_op(8'h00,  32'h0, 16'h0000, 32'h0, 1'b1, 5'd31, 32'h13579BDF, 0, 0, 32'h0);

        // Reset while waiting for load data, then a stray rvalid afterwards.
        @(negedge clock);
        in_valid = 1'b1; operator = OP_LW; operand_a = 32'h200; instruction = 32'h0;
        @(negedge clock); in_valid = 1'b0;
        check("wr_req", mem_req, 1);
        mem_grant = 1'b1;
        @(negedge clock); mem_grant = 1'b0;
        check("wr_wait", stall_request, 1);
        #1 reset = 1'b0;
        #1 check("wr_rst", {mem_req, out_valid, in_ready, stall_request}, 4'b0010);
        @(negedge clock); reset = 1'b1; mem_read_valid = 1'b1; mem_read_data = 32'h55AA55AA;
        @(negedge clock); mem_read_valid = 1'b0;
        check("wr_ignored", {out_valid, in_ready}, 2'b01);

        // Reset while the request is still outstanding.
        @(negedge clock);
        in_valid = 1'b1; operator = OP_SW; operand_a = 32'h300; instruction = 32'h0;
        @(negedge clock); in_valid = 1'b0;
        check("rr_req", mem_req, 1);
        #1 reset = 1'b0;
        #1 check("rr_rst", {mem_req, in_ready, stall_request}, 3'b010);
        @(negedge clock); reset = 1'b1;

        for (int t = 0; t < 200; t++) begin
            int unsigned r;
            logic [7:0]  op;
            r  = $urandom_range(0, 9);
            op = (r < 8) ? 8'(r + 1) : (8'h40 | 8'($urandom_range(0, 63)));
            do_op(op, $urandom, 16'($urandom), $urandom, 1'($urandom), 5'($urandom),
                  $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end

        @(negedge clock);
        check("final_drop", out_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
